// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with a pending-write scoreboard between decode and writeback.
// Same-cycle writeback data bypasses the array; register 0 can be hardwired to zero.
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int unsigned NumRegs = 1 << ADDR_W;
  localparam bit          ZeroEn  = (ZERO_REG != 0);

  logic [DATA_W-1:0]  regs_q [NumRegs];
  logic [NumRegs-1:0] pend_q, pend_d;
  logic [ADDR_W:0]    pend_cnt_q, pend_cnt_d;
  logic               wr_we;

  assign wr_we = wr_en && !(ZeroEn && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_we) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Set after clear so a same-cycle issue to the writeback target stays pending.
  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      if (wr_en) begin
        pend_d[wr_addr] = 1'b0;
      end
      if (iss_en) begin
        pend_d[iss_addr] = 1'b1;
      end
    end
    if (ZeroEn) begin
      pend_d[0] = 1'b0;
    end
  end

  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < NumRegs; i++) begin
      pend_cnt_d = pend_cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt = pend_cnt_q;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              zero_hit;
    logic              byp_hit;

    assign addr     = rd_addr[g*ADDR_W +: ADDR_W];
    assign zero_hit = ZeroEn && (addr == '0);
    assign byp_hit  = wr_en && (wr_addr == addr);

    assign rd_data[g*DATA_W +: DATA_W] = zero_hit ? '0      :
                                         byp_hit  ? wr_data :
                                                    regs_q[addr];
    assign rd_busy[g] = !zero_hit && !byp_hit && pend_q[addr];
  end

endmodule
